// File: rtl/scan_decoder_pkg.sv
// Shared definitions for scan_decoder.
// Holds the mode encodings carried on i_mode and the controller state type.
package scan_decoder_pkg;

  // Command modes
  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_SCAN   = 2'b10;
  localparam logic [1:0] MODE_OFF    = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

endpackage

// File: rtl/scan_decoder_dwell_timer.sv
// dwell_timer: loadable down-counter that paces the scan.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clr           force the count to zero (wins over load)
//   i_load          load i_load_val into the counter
//   i_load_val      value to load (hold cycles minus one)
//   i_en            counting enabled; o_done only asserted while enabled
//   o_done          high in the cycle where the count has reached zero
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_done
);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_load) begin
      count_d = i_load_val;
    end else if (i_en && (count_q != '0)) begin
      count_d = count_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_done = i_en && (count_q == '0);

endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot / thermometer / scanning decoder.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_valid/o_ready command handshake (accept when both high at an edge)
//   i_code          start/target index
//   i_mode          00 one-hot, 01 thermometer, 10 scan, 11 off
//   i_dwell         scan hold time in cycles minus one
//   i_stop          return to idle (ignored while already idle)
//   o_data          decoded pattern, o_valid flags it, o_code is its index
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int CODE_W  = 3,
  parameter int OUT_N   = 2**CODE_W,
  parameter int DWELL_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [CODE_W-1:0]  i_code,
  input  logic [1:0]         i_mode,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic               i_stop,
  output logic [OUT_N-1:0]   o_data,
  output logic               o_valid,
  output logic [CODE_W-1:0]  o_code
);

  state_e             state_q, state_d;
  logic [OUT_N-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic               ready_q, ready_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  logic               stop_eff;
  logic               accept;
  logic               tmr_done;
  logic               tmr_load;
  logic [DWELL_W-1:0] tmr_load_val;
  logic [OUT_N-1:0]   onehot;
  logic [OUT_N-1:0]   therm;

  // A stop only matters outside IDLE, and then it swallows any command.
  assign stop_eff = i_stop && (state_q != ST_IDLE);
  assign accept   = i_valid && ready_q && !stop_eff;

  assign onehot = OUT_N'(1) << i_code;

  for (genvar gi = 0; gi < OUT_N; gi++) begin : g_therm
    assign therm[gi] = (CODE_W'(gi) <= i_code);
  end

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (stop_eff),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .i_en       (state_q == ST_SCAN),
    .o_done     (tmr_done)
  );

  // State register (outputs live alongside it so all are registered)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ready_q <= 1'b1;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (stop_eff) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      case (i_mode)
        MODE_ONEHOT: state_d = ST_HOLD;
        MODE_THERM:  state_d = ST_HOLD;
        MODE_SCAN:   state_d = ST_SCAN;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    code_d       = code_q;
    dwell_d      = dwell_q;
    tmr_load     = 1'b0;
    tmr_load_val = dwell_q;
    if (stop_eff) begin
      data_d  = '0;
      valid_d = 1'b0;
      code_d  = '0;
    end else if (accept) begin
      dwell_d = i_dwell;
      case (i_mode)
        MODE_ONEHOT: begin
          data_d  = onehot;
          valid_d = 1'b1;
          code_d  = i_code;
        end
        MODE_THERM: begin
          data_d  = therm;
          valid_d = 1'b1;
          code_d  = i_code;
        end
        MODE_SCAN: begin
          data_d       = onehot;
          valid_d      = 1'b1;
          code_d       = i_code;
          tmr_load     = 1'b1;
          tmr_load_val = i_dwell;
        end
        default: begin
          data_d  = '0;
          valid_d = 1'b0;
          code_d  = '0;
        end
      endcase
    end else if ((state_q == ST_SCAN) && tmr_done) begin
      // Index wraps naturally since OUT_N == 2**CODE_W.
      data_d   = {data_q[OUT_N-2:0], data_q[OUT_N-1]};
      code_d   = code_q + CODE_W'(1);
      tmr_load = 1'b1;
    end
    ready_d = (state_d != ST_SCAN);
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_code  = code_q;
  assign o_ready = ready_q;

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter CODE_W, default 3, SHALL set the code width (legal range 1..6).
REQ-003 Parameter OUT_N, default 2**CODE_W, SHALL be derived only and never overridden; it sets the output vector width.
REQ-004 Parameter DWELL_W, default 8, SHALL set the dwell-count width.
REQ-005 i_clk  in  1  SHALL be the rising-edge clock.
REQ-006 i_rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-007 i_valid  in  1  SHALL flag a command present.
REQ-008 o_ready  out  1  SHALL flag that the block accepts a command.
REQ-009 i_code  in  CODE_W  SHALL be the start/target index.
REQ-010 i_mode  in  2  SHALL select the mode: 00 one-hot, 01 thermometer, 10 scan, 11 off.
REQ-011 i_dwell  in  DWELL_W  SHALL set the scan hold, in cycles minus one.
REQ-012 i_stop  in  1  SHALL request a return to idle.
REQ-013 o_data  out  OUT_N  SHALL be the registered decoded output.
REQ-014 o_valid  out  1  SHALL flag that o_data holds a decoded pattern.
REQ-015 o_code  out  CODE_W  SHALL give the index currently driven.

Function
REQ-016 States SHALL be IDLE, HOLD and SCAN; all outputs SHALL be registered.
REQ-017 A command SHALL be accepted when i_valid and o_ready are both 1 at a rising edge; i_code, i_mode and i_dwell SHALL be captured at acceptance.
REQ-018 o_ready SHALL be 1 in IDLE and HOLD, and 0 in SCAN.
REQ-019 Mode 00 SHALL produce o_data = 1 << i_code, o_valid = 1 and o_code = i_code one cycle after acceptance, then enter HOLD.
REQ-020 Mode 01 SHALL set o_data bits [i_code:0] to 1 and all others to 0, with one-cycle latency, then enter HOLD.
REQ-021 HOLD SHALL keep o_data/o_code stable until the next acceptance, which replaces the pattern with one-cycle latency.
REQ-022 Mode 10 SHALL, one cycle after acceptance, drive o_data = 1 << i_code with o_valid = 1, then enter SCAN.
REQ-023 In SCAN, each index SHALL be held i_dwell+1 cycles, then o_code SHALL increment and o_data SHALL rotate left by one.
REQ-024 Index OUT_N-1 SHALL wrap to 0.
REQ-025 i_dwell = 0 SHALL advance the scan every cycle.
REQ-026 Scan SHALL continue indefinitely until i_stop or reset.
REQ-027 Mode 11 SHALL be accepted, drive o_data = 0 and o_valid = 0 next cycle, and leave the state at IDLE.
REQ-028 i_stop in HOLD or SCAN SHALL force o_data = 0, o_valid = 0, o_code = 0 and state IDLE on the next edge.
REQ-029 i_stop SHALL take priority over an acceptance in the same cycle; the command SHALL be dropped.
REQ-030 i_stop in IDLE SHALL have no effect.
REQ-031 o_data SHALL never contain more than one 1 outside mode 01.

Reset
REQ-032 Reset assertion SHALL immediately set state to IDLE and o_data = 0, o_valid = 0, o_code = 0, dwell counter = 0, captured registers = 0; o_ready SHALL be 1 during reset.
REQ-033 Reset asserted mid-scan SHALL abort the scan with no further output change until a new acceptance.

Structure
REQ-034 A shared package SHALL hold the mode encodings (MODE_ONEHOT, MODE_THERM, MODE_SCAN, MODE_OFF) and the state enum type.
REQ-035 A sub-module, dwell_timer (load, count-down, done pulse, width DWELL_W), SHALL be instantiated once for scan pacing.

Verification
REQ-036 With CODE_W=3: accept mode 00, code 5 -> next cycle o_data = 0010_0000, o_valid = 1, o_code = 5, held stable for 10 cycles.
REQ-037 Accept mode 01, code 3 -> o_data = 0000_1111; then accept mode 00, code 0 -> o_data = 0000_0001 one cycle later.
REQ-038 Accept mode 10, code 6, dwell 2 -> o_data = 0100_0000 for 3 cycles, then 1000_0000 for 3, then wraps to 0000_0001; o_ready = 0 throughout.
REQ-039 During a scan with dwell 0, assert i_stop together with i_valid -> next cycle o_data = 0, o_valid = 0, state IDLE, command ignored.
REQ-040 Assert i_rst_n = 0 asynchronously mid-scan -> o_data = 0 before the next clock edge; after release, outputs stay 0 until an acceptance.
REQ-041 Rerun the scan scenario with CODE_W=4, code 15, dwell 0 -> o_data = 16'h8000, then 16'h0001.
